// File: rtl/bytecode_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bytecode_fetch_pkg
// Purpose  : Shared definitions for the bytecode fetch unit: fetch FSM state
//            encoding, request/word size constants and the request-length
//            normalisation helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bytecode_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no memory read outstanding
      ST_WAIT = 2'd1,   // read outstanding, data will be appended
      ST_DROP = 2'd2    // read outstanding, data will be discarded
   } fetch_state_e;

   localparam int MAX_REQ    = 4;
   localparam int WORD_BYTES = 4;

   // A request length of 0 or anything above MAX_REQ means "MAX_REQ bytes".
   function automatic logic [2:0] eff_len(input logic [2:0] len);
      if ((len == 3'd0) || (len > 3'(MAX_REQ))) begin
         return 3'(MAX_REQ);
      end
      return len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bytecode_fetch_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Purpose  : Circular byte buffer accepting up to four bytes per cycle and
//            releasing up to four bytes per cycle; the four oldest bytes are
//            always visible on peek_data (lanes past the fill level carry
//            stale data and must be masked by the user).
// Ports    : clk, reset      - clock / synchronous active-high reset
//            flush           - empty the buffer (wins over push/pop)
//            push_cnt/data   - number of bytes and bytes to append (byte 0 at [7:0])
//            pop_cnt         - number of bytes to drop from the head
//            peek_data       - four head bytes, head at [7:0]
//            count           - current fill level in bytes
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo
#(
   parameter int DEPTH = 8
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [2:0]               push_cnt,
   input  logic [31:0]              push_data,
   input  logic [2:0]               pop_cnt,
   output logic [31:0]              peek_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [7:0]  mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q,  count_d;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
      wr_ptr_d = wr_ptr_q + PW'(push_cnt);
      count_d  = count_q + (PW+1)'(push_cnt) - (PW+1)'(pop_cnt);
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < push_cnt) begin
            mem_d[wr_ptr_q + PW'(i)] = push_data[8*i +: 8];
         end
      end
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   always_comb begin
      peek_data = '0;
      for (int i = 0; i < 4; i++) begin
         peek_data[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
      end
   end

   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/bytecode_fetch.sv
`default_nettype none
// ============================================================================
// Module   : bytecode_fetch
// Purpose  : Prefetches 32-bit words from an external memory into a byte
//            buffer and presents a variable-length (1..4 byte) window at the
//            head PC. Supports redirection to any byte alignment at any time,
//            discarding an in-flight read when needed.
// Ports    : clk, reset        - clock / synchronous active-high reset
//            redirect/_pc      - load new head PC, flush buffer
//            req_len/req_valid - consumer request (0 or >4 means 4)
//            out_bytes/valid   - head bytes (masked) and "enough bytes" flag
//            head_pc           - byte PC of out_bytes[7:0]
//            mem_addr/start    - word read request, held until mem_ready
//            mem_ready/data    - read completion and data
// Revision : 1.0 - initial release
// ============================================================================
module bytecode_fetch
   import bytecode_fetch_pkg::*;
#(
   parameter int RAM_SIZE      = 256,
   parameter int ADDRESS_WIDTH = 10,
   parameter int FIFO_DEPTH    = 8
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     redirect,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   input  logic [2:0]               req_len,
   input  logic                     req_valid,
   output logic [31:0]              out_bytes,
   output logic                     out_valid,
   output logic [ADDRESS_WIDTH-1:0] head_pc,
   output logic [ADDRESS_WIDTH-3:0] mem_addr,
   output logic                     mem_start,
   input  logic                     mem_ready,
   input  logic [31:0]              mem_data
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Reject configurations the buffer arithmetic cannot support.
   if ((FIFO_DEPTH < 8) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
       (RAM_SIZE < 1) || (RAM_SIZE > (1 << (ADDRESS_WIDTH - 2)))) begin : g_bad_params
      $error("bytecode_fetch: illegal parameter set");
   end

   fetch_state_e               state_q,     state_d;
   logic [ADDRESS_WIDTH-1:0]   head_pc_q,   head_pc_d;
   logic [ADDRESS_WIDTH-3:0]   fetch_ptr_q, fetch_ptr_d;
   logic [1:0]                 offset_q,    offset_d;
   logic                       mem_start_q, mem_start_d;
   logic [ADDRESS_WIDTH-3:0]   mem_addr_q,  mem_addr_d;

   logic [CW-1:0]  fifo_count;
   logic [31:0]    fifo_peek;
   logic [2:0]     len_eff;
   logic           consume;
   logic           flush;
   logic           free_ok;
   logic [2:0]     push_cnt;
   logic [31:0]    push_data;
   logic [2:0]     pop_cnt;

   assign len_eff   = eff_len(req_len);
   assign out_valid = (fifo_count >= CW'(len_eff));
   // Redirect wins over a same-cycle consume.
   assign consume   = req_valid & out_valid & ~redirect;
   assign pop_cnt   = consume ? len_eff : 3'd0;
   // A whole word must fit before a read is issued, so appends never overflow.
   assign free_ok   = ((CW'(FIFO_DEPTH) - fifo_count) >= CW'(WORD_BYTES));
   // Bytes below the fetch offset belong to addresses before the redirect PC.
   assign push_data = mem_data >> {offset_q, 3'b000};

   // Lanes beyond the requested length or the buffer fill level read as zero.
   always_comb begin
      out_bytes = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if ((3'(i) < len_eff) && (CW'(i) < fifo_count)) begin
            out_bytes[8*i +: 8] = fifo_peek[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      head_pc_d   = head_pc_q + (consume ? ADDRESS_WIDTH'(len_eff) : '0);
      fetch_ptr_d = fetch_ptr_q;
      offset_d    = offset_q;
      mem_start_d = mem_start_q;
      mem_addr_d  = mem_addr_q;
      flush       = 1'b0;
      push_cnt    = 3'd0;

      if (redirect) begin
         flush       = 1'b1;
         head_pc_d   = redirect_pc;
         fetch_ptr_d = redirect_pc[ADDRESS_WIDTH-1:2];
         offset_d    = redirect_pc[1:0];
      end

      case (state_q)
         ST_IDLE: begin
            if (!redirect && free_ok) begin
               state_d     = ST_WAIT;
               mem_start_d = 1'b1;
               mem_addr_d  = fetch_ptr_q;
            end
         end
         ST_WAIT: begin
            if (mem_ready) begin
               state_d     = ST_IDLE;
               mem_start_d = 1'b0;
               if (!redirect) begin
                  push_cnt    = 3'(WORD_BYTES) - {1'b0, offset_q};
                  fetch_ptr_d = fetch_ptr_q + (ADDRESS_WIDTH-2)'(1);
                  offset_d    = 2'd0;
               end
            end else if (redirect) begin
               // Memory cannot be cancelled: keep the request up, drop its data.
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (mem_ready) begin
               state_d     = ST_IDLE;
               mem_start_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            mem_start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         head_pc_q   <= '0;
         fetch_ptr_q <= '0;
         offset_q    <= '0;
         mem_start_q <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         head_pc_q   <= head_pc_d;
         fetch_ptr_q <= fetch_ptr_d;
         offset_q    <= offset_d;
         mem_start_q <= mem_start_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   assign head_pc   = head_pc_q;
   assign mem_start = mem_start_q;
   assign mem_addr  = mem_addr_q;

   byte_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop_cnt   (pop_cnt),
      .peek_data (fifo_peek),
      .count     (fifo_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_bytecode_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bytecode_fetch
// Purpose  : Self-checking bench for bytecode_fetch with a behavioural
//            word memory of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bytecode_fetch;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic [2:0]    req_len = 3'd1;
   logic          req_valid = 1'b0;
   logic [31:0]   out_bytes;
   logic          out_valid;
   logic [AW-1:0] head_pc;
   logic [AW-3:0] mem_addr;
   logic          mem_start;
   logic          mem_ready = 1'b0;
   logic [31:0]   mem_data = '0;

   int checks = 0;
   int failures = 0;
   int mem_lat = 1;
   int lat_cnt = 0;

   typedef struct {
      logic [31:0]   bytes;
      logic [AW-1:0] pc;
   } exp_t;

   typedef struct {
      logic [AW-1:0] pc;
      logic [2:0]    len;
      logic [31:0]   exp_bytes;
      logic [AW-1:0] exp_next;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[7];

   bytecode_fetch #(
      .RAM_SIZE      (256),
      .ADDRESS_WIDTH (AW),
      .FIFO_DEPTH    (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .req_len     (req_len),
      .req_valid   (req_valid),
      .out_bytes   (out_bytes),
      .out_valid   (out_valid),
      .head_pc     (head_pc),
      .mem_addr    (mem_addr),
      .mem_start   (mem_start),
      .mem_ready   (mem_ready),
      .mem_data    (mem_data)
   );

   always #5 clk = ~clk;

   // Memory image: bytes 0..7 are 0x11..0x88, everything else (3a+1) mod 256.
   function automatic logic [7:0] byte_at(input int a);
      if (a < 8) return 8'(8'h11 * (a + 1));
      return 8'(a * 3 + 1);
   endfunction

   function automatic logic [31:0] word_at(input logic [AW-3:0] w);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = byte_at(int'(w) * 4 + k);
      return r;
   endfunction

   function automatic logic [31:0] window(input int pc, input int len);
      logic [31:0] r = '0;
      for (int k = 0; k < len; k++) r[8*k +: 8] = byte_at((pc + k) % 1024);
      return r;
   endfunction

   // Memory model: mem_ready is a one-cycle pulse mem_lat cycles after start.
   always @(negedge clk) begin
      if (reset) begin
         mem_ready = 1'b0;
         lat_cnt   = 0;
      end else if (mem_ready) begin
         mem_ready = 1'b0;
      end else if (mem_start) begin
         lat_cnt = lat_cnt + 1;
         if (lat_cnt >= mem_lat) begin
            mem_ready = 1'b1;
            mem_data  = word_at(mem_addr);
            lat_cnt   = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; redirect = 1'b0; req_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int budget);
      for (int i = 0; i < budget && out_valid !== 1'b1; i++) @(negedge clk);
      chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic pop_compare(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s scoreboard empty actual=output expected=none", name);
      end else begin
         e = sb.pop_front();
         chk({name, "_bytes"}, out_bytes, e.bytes);
         chk({name, "_pc"}, {22'd0, head_pc}, {22'd0, e.pc});
      end
   endtask

   // Holds req_valid and compares every consumed window against the scoreboard.
   task automatic stream(input string name, input int n, input int budget);
      int got = 0;
      req_valid = 1'b1;
      for (int c = 0; c < budget && got < n; c++) begin
         if (out_valid) begin
            pop_compare(name);
            got++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk({name, "_count"}, got, n);
   endtask

   task automatic find_wait_word1(input string name);
      bit found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         @(posedge clk); #1;
         if (mem_start && mem_addr == 8'd1) found = 1'b1;
      end
      chk({name, "_found"}, {31'd0, found}, 32'd1);
   endtask

   initial begin
      vecs[0] = '{pc: 10'h005, len: 3'd3, exp_bytes: 32'h0088_7766, exp_next: 10'h008};
      vecs[1] = '{pc: 10'h000, len: 3'd4, exp_bytes: 32'h4433_2211, exp_next: 10'h004};
      vecs[2] = '{pc: 10'h002, len: 3'd2, exp_bytes: 32'h0000_4433, exp_next: 10'h004};
      vecs[3] = '{pc: 10'h007, len: 3'd0, exp_bytes: 32'h1F1C_1988, exp_next: 10'h00B};
      vecs[4] = '{pc: 10'h001, len: 3'd5, exp_bytes: 32'h5544_3322, exp_next: 10'h005};
      vecs[5] = '{pc: 10'h3FE, len: 3'd4, exp_bytes: 32'h2211_FEFB, exp_next: 10'h002};
      vecs[6] = '{pc: 10'h3FE, len: 3'd1, exp_bytes: 32'h0000_00FB, exp_next: 10'h3FF};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_bytes", out_bytes, 32'd0);
      chk("rst_head_pc", {22'd0, head_pc}, 32'd0);
      chk("rst_mem_start", {31'd0, mem_start}, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      reset = 1'b0;

      // Sequential single-byte consumption from PC 0
      for (int i = 0; i < 8; i++) sb.push_back('{bytes: 32'(8'h11 * (i + 1)), pc: AW'(i)});
      req_len = 3'd1;
      stream("seq1", 8, 100);

      // Full-rate 4-byte consumption over 64 bytes
      @(negedge clk);
      redirect = 1'b1; redirect_pc = '0; req_len = 3'd4;
      @(negedge clk);
      redirect = 1'b0;
      for (int i = 0; i < 16; i++) sb.push_back('{bytes: window(4 * i, 4), pc: AW'(4 * i)});
      stream("seq4", 16, 400);

      // Table of redirect targets and request lengths
      foreach (vecs[v]) begin
         @(negedge clk);
         redirect = 1'b1; redirect_pc = vecs[v].pc; req_len = vecs[v].len; req_valid = 1'b0;
         @(negedge clk);
         redirect = 1'b0;
         sb.push_back('{bytes: vecs[v].exp_bytes, pc: vecs[v].pc});
         wait_valid($sformatf("vec%0d", v), 40);
         pop_compare($sformatf("vec%0d", v));
         req_valid = 1'b1;
         @(negedge clk);
         req_valid = 1'b0;
         chk($sformatf("vec%0d_next_pc", v), {22'd0, head_pc}, {22'd0, vecs[v].exp_next});
      end

      // Redirect while the read of word 1 is outstanding
      mem_lat = 4;
      do_reset();
      find_wait_word1("drop");
      redirect = 1'b1; redirect_pc = 10'h010; req_len = 3'd1; req_valid = 1'b0;
      @(posedge clk); #1;
      redirect = 1'b0;
      chk("drop_hold_start", {31'd0, mem_start}, 32'd1);
      chk("drop_hold_addr", {24'd0, mem_addr}, 32'd1);
      sb.push_back('{bytes: 32'h31, pc: 10'h010});
      sb.push_back('{bytes: 32'h34, pc: 10'h011});
      @(negedge clk);
      stream("drop_seq", 2, 80);

      // Redirect coincident with mem_ready and an accepted request
      mem_lat = 1;
      do_reset();
      begin
         bit found = 1'b0;
         for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk); #1;
            if (mem_ready && out_valid) found = 1'b1;
         end
         chk("coin_found", {31'd0, found}, 32'd1);
      end
      redirect = 1'b1; redirect_pc = 10'h020; req_valid = 1'b1; req_len = 3'd1;
      @(posedge clk); #1;
      redirect = 1'b0; req_valid = 1'b0;
      chk("coin_head_pc", {22'd0, head_pc}, 32'h020);
      chk("coin_out_valid", {31'd0, out_valid}, 32'd0);
      chk("coin_out_bytes", out_bytes, 32'd0);
      sb.push_back('{bytes: 32'h61, pc: 10'h020});
      @(negedge clk);
      wait_valid("coin_after", 40);
      pop_compare("coin_after");

      // Reset in the middle of an outstanding read
      mem_lat = 4;
      do_reset();
      find_wait_word1("rstw");
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rstw_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rstw_out_bytes", out_bytes, 32'd0);
      chk("rstw_head_pc", {22'd0, head_pc}, 32'd0);
      chk("rstw_mem_start", {31'd0, mem_start}, 32'd0);
      chk("rstw_mem_addr", {24'd0, mem_addr}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      begin
         bit found = 1'b0;
         for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (mem_start) found = 1'b1;
         end
         chk("rstw_restart", {31'd0, found}, 32'd1);
         chk("rstw_restart_addr", {24'd0, mem_addr}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
